// File: rtl/axi_wr_slave_pkg.sv
// Shared constants and types for the AXI write-channel front end of the DDR2 controller.
// Holds the DDR2 geometry (address and data widths), the B-channel response codes and the
// state encoding of the write-slave FSM.
package axi_wr_slave_pkg;

    localparam int unsigned ROW_BITS = 13;
    localparam int unsigned COL_BITS = 10;
    localparam int unsigned BA_BITS  = 3;
    localparam int unsigned DQ_BITS  = 16;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StDrain,
        StWait,
        StResp
    } wr_state_e;

endpackage

// File: rtl/axi_wr_slave_sync_fifo.sv
// Single-clock first-word-fall-through FIFO for buffered write beats.
// Ports:
//   clk_i, rstn_i    clock and synchronous active-low reset (empties the FIFO)
//   push_i, wdata_i  write side; a push while full is ignored
//   full_o           no free entry
//   pop_i, rdata_o   read side; rdata_o is the current head, valid while !empty_o
//   empty_o          no stored entry
module axi_wr_slave_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW + 1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW + 1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/axi_wr_slave.sv
// AXI write-channel front end of the DDR2 controller. Accepts one AW/W/B transaction at a
// time, buffers the beats in a FIFO, issues a single write command to the scheduler, streams
// the beats to the DDR2 write datapath and answers on B once the core reports completion.
// Ports:
//   clk_i, rstn_i                      clock, synchronous active-low reset
//   aw*_i/awready_o                    AXI write address channel
//   w*_i/wready_o                      AXI write data channel
//   b*_o/bready_i                      AXI write response channel
//   cmd_valid_o/cmd_ready_i, cmd_*_o   write command toward the DDR2 scheduler
//   wd_valid_o/wd_ready_i, wd_data_o   buffered beats toward the DDR2 write datapath
//   wr_done_i                          one-cycle pulse: core finished the burst
module axi_wr_slave
    import axi_wr_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ROW_BITS + COL_BITS + BA_BITS,
    parameter int unsigned DATA_WIDTH = DQ_BITS * 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  MAX_LEN    = 8'd15
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [7:0]            awlen_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic                  wlast_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [1:0]            bresp_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    output logic [7:0]            cmd_len_o,
    output logic                  wd_valid_o,
    input  logic                  wd_ready_i,
    output logic [DATA_WIDTH-1:0] wd_data_o,
    input  logic                  wr_done_i
);

    wr_state_e             state_q;
    logic                  awready_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [7:0]            cmd_len_q;
    logic [7:0]            cnt_q;
    logic                  err_q;
    logic                  beats_done_q;  // final beat of the burst already accepted
    logic                  cmd_done_q;    // scheduler already took the command

    logic fifo_full, fifo_empty;
    logic w_fire, cmd_fire, last_beat, push;

    assign awready_o   = awready_q;
    // Once the counted final beat is in, further beats must not be pushed.
    assign wready_o    = ((state_q == StData) && !beats_done_q && !fifo_full) ||
                         (state_q == StDrain);
    assign cmd_valid_o = (state_q == StData) && !cmd_done_q;
    assign bvalid_o    = (state_q == StResp);
    assign bresp_o     = ((state_q == StResp) && err_q) ? BRESP_SLVERR : BRESP_OKAY;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_len_o   = cmd_len_q;
    assign wd_valid_o  = !fifo_empty;

    assign w_fire    = wvalid_i && wready_o;
    assign cmd_fire  = cmd_valid_o && cmd_ready_i;
    assign last_beat = (cnt_q == cmd_len_q);
    assign push      = w_fire && (state_q == StData);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= StIdle;
            awready_q    <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            beats_done_q <= 1'b0;
            cmd_done_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (awvalid_i && awready_q) begin
                        awready_q    <= 1'b0;
                        cmd_addr_q   <= awaddr_i;
                        cmd_len_q    <= awlen_i;
                        cnt_q        <= '0;
                        beats_done_q <= 1'b0;
                        cmd_done_q   <= 1'b0;
                        if (awlen_i > MAX_LEN) begin
                            err_q   <= 1'b1;
                            state_q <= StDrain;
                        end else begin
                            state_q <= StData;
                        end
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                StData: begin
                    // The beat count decides the end of the burst; wlast only flags errors.
                    if (w_fire) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (last_beat) begin
                            beats_done_q <= 1'b1;
                            if (!wlast_i) err_q <= 1'b1;
                        end else if (wlast_i) begin
                            err_q <= 1'b1;
                        end
                    end
                    if (cmd_fire) cmd_done_q <= 1'b1;
                    if ((beats_done_q || (w_fire && last_beat)) && (cmd_done_q || cmd_fire)) begin
                        state_q <= StWait;
                    end
                end
                StDrain: begin
                    if (wvalid_i && wlast_i) state_q <= StResp;
                end
                StWait: begin
                    if (wr_done_i) state_q <= StResp;
                end
                StResp: begin
                    if (bready_i) begin
                        err_q     <= 1'b0;
                        awready_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    axi_wr_slave_sync_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push_i (push),
        .wdata_i(wdata_i),
        .full_o (fifo_full),
        .pop_i  (wd_ready_i),
        .rdata_o(wd_data_o),
        .empty_o(fifo_empty)
    );

endmodule

// File: tb/tb_axi_wr_slave.sv
module tb_axi_wr_slave;
    import axi_wr_slave_pkg::*;

    localparam int unsigned AW = ROW_BITS + COL_BITS + BA_BITS;
    localparam int unsigned DW = DQ_BITS * 2;
    localparam int MaxLen = 15;
    localparam int Bound  = 500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          wvalid, wready, wlast;
    logic [DW-1:0] wdata;
    logic          bvalid, bready;
    logic [1:0]    bresp;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic          wr_done;

    axi_wr_slave dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .awvalid_i  (awvalid),
        .awready_o  (awready),
        .awaddr_i   (awaddr),
        .awlen_i    (awlen),
        .wvalid_i   (wvalid),
        .wready_o   (wready),
        .wlast_i    (wlast),
        .wdata_i    (wdata),
        .bvalid_o   (bvalid),
        .bready_i   (bready),
        .bresp_o    (bresp),
        .cmd_valid_o(cmd_valid),
        .cmd_ready_i(cmd_ready),
        .cmd_addr_o (cmd_addr),
        .cmd_len_o  (cmd_len),
        .wd_valid_o (wd_valid),
        .wd_ready_i (wd_ready),
        .wd_data_o  (wd_data),
        .wr_done_i  (wr_done)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } cmd_t;

    // Expected traffic, filled by the transaction model.
    cmd_t          exp_cmd_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [1:0]    exp_b_q[$];

    int n_pass, n_total;
    int cmd_count, pop_count, b_count;
    bit done_ok;
    logic [AW-1:0] last_cmd_addr;
    logic [7:0]    last_cmd_len;
    logic [1:0]    last_bresp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: got no event, expected one within %0d cycles", name, Bound);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "bench stopped early");
    endtask

    // Transaction model: what a burst of len+1 beats with wlast on beat last_pos must produce.
    task automatic model_txn(input logic [AW-1:0] addr, input int len, input int last_pos,
                             input logic [DW-1:0] base);
        bit err;
        cmd_t c;
        err = (len > MaxLen) || (last_pos != len);
        if (len <= MaxLen) begin
            c.addr = addr;
            c.len  = 8'(len);
            exp_cmd_q.push_back(c);
            for (int i = 0; i <= len; i++) exp_data_q.push_back(base + DW'(i));
        end
        exp_b_q.push_back(err ? 2'b10 : 2'b00);
        // An oversize burst answers without any wr_done.
        done_ok = (len > MaxLen);
    endtask

    function automatic int counter(input int which);
        case (which)
            0:       return cmd_count;
            1:       return pop_count;
            default: return b_count;
        endcase
    endfunction

    task automatic wait_until(input string name, input int which, input int target);
        int k;
        k = 0;
        while (counter(which) < target) begin
            @(posedge clk);
            k++;
            if (k > Bound) timeout(name);
        end
        #1;
    endtask

    task automatic do_aw(input logic [AW-1:0] addr, input int len);
        int k;
        awvalid = 1'b1;
        awaddr  = addr;
        awlen   = 8'(len);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k > Bound) timeout("aw_handshake");
        end while (!awready);
        @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic send_beats(input int n, input int last_pos, input logic [DW-1:0] base);
        int k;
        for (int i = 0; i < n; i++) begin
            wvalid = 1'b1;
            wdata  = base + DW'(i);
            wlast  = (i == last_pos);
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (k > Bound) timeout("w_handshake");
            end while (!wready);
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic pulse_done();
        done_ok = 1'b1;
        wr_done = 1'b1;
        @(posedge clk);
        #1 wr_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_awready"}, 64'(awready), 64'd0);
        check({pfx, "_wready"}, 64'(wready), 64'd0);
        check({pfx, "_bvalid"}, 64'(bvalid), 64'd0);
        check({pfx, "_bresp"}, 64'(bresp), 64'd0);
        check({pfx, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check({pfx, "_wd_valid"}, 64'(wd_valid), 64'd0);
        check({pfx, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
        check({pfx, "_cmd_len"}, 64'(cmd_len), 64'd0);
    endtask

    // Compare process: every handshake that will complete on the next rising edge.
    bit            stall_prev;
    logic [AW-1:0] stall_addr;
    logic [7:0]    stall_len;
    cmd_t          e;
    always @(negedge clk) begin
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                cmd_count++;
                last_cmd_addr = cmd_addr;
                last_cmd_len  = cmd_len;
                if (exp_cmd_q.size() == 0) begin
                    n_total++;
                    $display("FAIL cmd_unexpected: got command addr=%0h len=%0d, expected none",
                             cmd_addr, cmd_len);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
                    check("cmd_len", 64'(cmd_len), 64'(e.len));
                end
            end
            if (cmd_valid && !cmd_ready) begin
                if (stall_prev) begin
                    check("cmd_addr_stable", 64'(cmd_addr), 64'(stall_addr));
                    check("cmd_len_stable", 64'(cmd_len), 64'(stall_len));
                end
                stall_prev = 1'b1;
                stall_addr = cmd_addr;
                stall_len  = cmd_len;
            end else begin
                stall_prev = 1'b0;
            end
            if (wd_valid && wd_ready) begin
                pop_count++;
                if (exp_data_q.size() == 0) begin
                    n_total++;
                    $display("FAIL wd_unexpected: got wd_data=%0h, expected no beat", wd_data);
                end else begin
                    check("wd_data", 64'(wd_data), 64'(exp_data_q.pop_front()));
                end
            end
            if (bvalid && bready) begin
                b_count++;
                last_bresp = bresp;
                if (exp_b_q.size() == 0) begin
                    n_total++;
                    $display("FAIL b_unexpected: got bresp=%0b, expected no response", bresp);
                end else begin
                    check("bresp", 64'(bresp), 64'(exp_b_q.pop_front()));
                end
                check("b_after_done", 64'(done_ok), 64'd1);
            end
        end
    end

    initial begin
        rstn = 1'b0; awvalid = 1'b0; awaddr = '0; awlen = '0;
        wvalid = 1'b0; wlast = 1'b0; wdata = '0;
        bready = 1'b1; cmd_ready = 1'b1; wd_ready = 1'b1; wr_done = 1'b0;
        n_pass = 0; n_total = 0; cmd_count = 0; pop_count = 0; b_count = 0;
        done_ok = 1'b0; last_cmd_addr = '0; last_cmd_len = '0; last_bresp = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Nominal 9-beat burst.
        model_txn(AW'(32'h40), 8, 8, 32'd0);
        do_aw(AW'(32'h40), 8);
        send_beats(9, 8, 32'd0);
        wait_until("t1_cmd", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        pulse_done();
        wait_until("t1_b", 2, 1);
        check("t1_cmd_addr", 64'(last_cmd_addr), 64'h40);
        check("t1_cmd_len", 64'(last_cmd_len), 64'd8);
        check("t1_pops", 64'(pop_count), 64'd9);
        check("t1_bresp", 64'(last_bresp), 64'd0);

        // 16 beats with the datapath stalled: FIFO fills, then drains in order.
        wd_ready = 1'b0;
        model_txn(AW'(32'h123), 15, 15, 32'h100);
        do_aw(AW'(32'h123), 15);
        send_beats(16, 15, 32'h100);
        @(negedge clk);
        check("t2_wready_full", 64'(wready), 64'd0);
        check("t2_wd_valid", 64'(wd_valid), 64'd1);
        @(posedge clk);
        #1 wd_ready = 1'b1;
        wait_until("t2_drain", 1, 25);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t2_no_b_before_done", 64'(bvalid), 64'd0);
        @(posedge clk);
        #1;
        pulse_done();
        wait_until("t2_b", 2, 2);
        check("t2_pops", 64'(pop_count), 64'd25);
        check("t2_bresp", 64'(last_bresp), 64'd0);

        // Early wlast: all four beats still taken, SLVERR returned.
        model_txn(AW'(32'h200), 3, 1, 32'h200);
        do_aw(AW'(32'h200), 3);
        send_beats(4, 1, 32'h200);
        wait_until("t3_cmd", 0, 3);
        pulse_done();
        wait_until("t3_b", 2, 3);
        check("t3_pops", 64'(pop_count), 64'd29);
        check("t3_bresp", 64'(last_bresp), 64'h2);

        // Oversize burst: drained without command or data, SLVERR.
        model_txn(AW'(32'h300), 20, 20, 32'h300);
        do_aw(AW'(32'h300), 20);
        send_beats(21, 20, 32'h300);
        wait_until("t4_b", 2, 4);
        check("t4_cmds", 64'(cmd_count), 64'd3);
        check("t4_pops", 64'(pop_count), 64'd29);
        check("t4_bresp", 64'(last_bresp), 64'h2);

        // Scheduler stalled while the beats arrive.
        cmd_ready = 1'b0;
        model_txn(AW'(32'h1abc), 7, 7, 32'h500);
        do_aw(AW'(32'h1abc), 7);
        send_beats(8, 7, 32'h500);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_cmd_valid_held", 64'(cmd_valid), 64'd1);
        check("t5_cmd_addr", 64'(cmd_addr), 64'h1abc);
        check("t5_cmd_len", 64'(cmd_len), 64'd7);
        check("t5_no_b", 64'(bvalid), 64'd0);
        @(posedge clk);
        #1 cmd_ready = 1'b1;
        wait_until("t5_cmd", 0, 4);
        pulse_done();
        wait_until("t5_b", 2, 5);
        check("t5_pops", 64'(pop_count), 64'd37);
        check("t5_bresp", 64'(last_bresp), 64'd0);

        // Reset after two beats aborts the burst; the next burst is clean.
        cmd_ready = 1'b0;
        wd_ready  = 1'b0;
        model_txn(AW'(32'h600), 3, 3, 32'h600);
        do_aw(AW'(32'h600), 3);
        send_beats(2, 3, 32'h600);
        rstn = 1'b0;
        exp_cmd_q.delete();
        exp_data_q.delete();
        exp_b_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t6");
        @(posedge clk);
        #1 rstn = 1'b1;
        cmd_ready = 1'b1;
        wd_ready  = 1'b1;
        model_txn(AW'(32'h700), 1, 1, 32'h700);
        do_aw(AW'(32'h700), 1);
        send_beats(2, 1, 32'h700);
        wait_until("t6_cmd", 0, 5);
        pulse_done();
        wait_until("t6_b", 2, 6);
        check("t6_pops", 64'(pop_count), 64'd39);
        check("t6_bresp", 64'(last_bresp), 64'd0);
        check("t6_bcount", 64'(b_count), 64'd6);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
